carrier_derotator: RTL and testbench
====================================

# carrier_derotator

Upstream companion of the Costas phase-recovery loop: rotates each complex baseband sample by minus the sum of a free-running NCO angle and the loop's phase correction, and hands the derotated I/Q to the loop. It uses a quarter-wave sine LUT, four pipeline stages, and a per-sample valid qualifier. It also has a sticky saturation flag. The loop's 16-bit phase output connects directly to `phase_i`.

## Interface
Parameters:
- `LUT_BITS`, default 10: phase resolution, N = 2^LUT_BITS points per turn. Quarter-wave table holds N/4+1 entries. Legal range 6..14.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `enbl_i`  in  1  block enable; low clears the NCO and the overflow flag
- `valid_i`  in  1  `dataI_i`/`dataQ_i` hold a sample this cycle
- `dataI_i`, `dataQ_i`  in  16  signed Q1.15 input sample
- `freq_i`  in  32  NCO tuning word; 2^32 = one turn per sample
- `phase_i`  in  16  signed correction angle; 2^16 = one turn
- `dataI_o`, `dataQ_o`  out  16  signed Q1.15 derotated sample
- `valid_o`  out  1  output sample valid
- `ovf_o`  out  1  sticky: at least one output was saturated

## Operation
- NCO: 32-bit accumulator `acc`.
  - On each cycle with `valid_i` and `enbl_i` high: `acc <= acc + freq_i`, with modulo-2^32 wrap.
  - With `enbl_i` low: `acc <= 0`.
- Angle for a sample: `theta = acc[31:16] + phase_i`, modulo 2^16.
  - Uses `acc` before that sample's update, so the first sample after reset or enable sees `acc = 0`.
  - With `enbl_i` low, `theta = 0`.
- LUT: `S[k] = round(32767·sin(2πk/N))` for k = 0..N/4.
  - `q = theta[15:14]`, `r = theta[13:16-LUT_BITS]`.
  - sin: q0 → `S[r]`; q1 → `S[N/4-r]`; q2 → `-S[r]`; q3 → `-S[N/4-r]`.
  - cos(theta) is computed as sin(theta + N/4), applied at table index level.
- Derotation (multiply by e^-jθ):
  - `I' = I·cos + Q·sin`
  - `Q' = Q·cos − I·sin`
- Arithmetic widths:
  - Products are 32-bit signed; sums are 33-bit.
  - Round by adding 2^14, then arithmetic-shift right by 15.
  - Saturate the result to [−32768, 32767].
- `ovf_o`:
  - Set on any valid output that was clipped.
  - Cleared only by `rst_i` or by `enbl_i` low. If clipping and `enbl_i` low occur in the same cycle, clear wins.
- Samples flow with or without `enbl_i`; no back-pressure. Samples without `valid_i` are discarded, and `acc` holds.

## Timing
- Pipeline stages, with input data and valid delayed alongside:
  - S1: register `theta`, `dataI_i`, `dataQ_i`, and `valid_i`.
  - S2: registered LUT read (sin, cos).
  - S3: four products registered.
  - S4: sum, round, saturate, then register the outputs.
- Latency is exactly 4 cycles from `valid_i` to `valid_o`, one sample per cycle sustained. Bubbles are preserved.
- `freq_i` affects the angle from the next valid sample onward. `phase_i` is sampled in the same cycle as its `valid_i`.
- Reset (async assert, any time, including mid-stream):
  - All outputs go to 0 and `acc` goes to 0.
  - All stage valids clear; in-flight samples are dropped.
  - First `valid_o` appears no earlier than 4 cycles after the first post-release `valid_i`.
- Payload outputs hold their last value while `valid_o` is low.

## Configuration
- `DEROT_NCO_EN` defined: NCO accumulator is present and `freq_i` is used as described above.
- Not defined:
  - No accumulator is synthesised; `freq_i` is ignored.
  - `theta = phase_i` when `enbl_i` is high, and 0 when it is low.
  - Latency and all other behaviour are unchanged.

## Test plan
All cases use LUT_BITS = 10 and `enbl_i` = 1 unless stated.

- **Reset:** assert `rst_i` mid-stream. Required: `dataI_o`/`dataQ_o`/`valid_o`/`ovf_o` = 0 immediately. Release, send one sample; `valid_o` goes high exactly 4 cycles later.
- **Zero angle:** `freq_i` = 0, `phase_i` = 0, I = 16384, Q = −8192. Required: after 4 cycles, I' = 16384, Q' = −8192.
- **Quarter turn:** `phase_i` = 16'h4000, I = 16384, Q = 0. Required: I' = 0, Q' = −16383.
- **Saturation:** `phase_i` = 16'h2000, I = Q = −32768 (cos = sin = 23170). Required: I' = −32768, Q' = 0, `ovf_o` = 1. Then drop `enbl_i` for 1 cycle; required: `ovf_o` = 0.
- **NCO steps (macro defined):** `freq_i` = 32'h4000_0000, I = 16384, Q = 0, four samples with one idle gap between samples 2 and 3. Required outputs in order: (16384, 0), (0, −16383), (−16383, 0), (0, 16384), with a matching `valid_o` bubble.
- **Macro undefined:** repeat the NCO-steps stimulus. Required: all four outputs = (16384, 0).

Source files
------------

// File: rtl/carrier_derotator.sv
// ============================================================================
// carrier_derotator
//
// Rotates each complex baseband sample by minus (NCO angle + loop phase
// correction) and hands the derotated I/Q to the Costas loop.
// Four-stage pipeline, quarter-wave sine ROM, per-sample valid, sticky
// saturation flag.
//
// Build option:
//   DEROT_NCO_EN  defined   : 32-bit NCO accumulator present and driven by freq_i
//                 undefined : no accumulator, freq_i ignored, theta = phase_i
//
// Parameters:
//   LUT_BITS  phase resolution, N = 2^LUT_BITS points per turn (6..14)
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   enbl_i           block enable; low clears NCO and overflow flag, theta = 0
//   valid_i          input sample valid
//   dataI_i/dataQ_i  signed Q1.15 input sample
//   freq_i           NCO tuning word (2^32 = one turn per sample)
//   phase_i          signed correction angle (2^16 = one turn)
//   dataI_o/dataQ_o  signed Q1.15 derotated sample (held while valid_o low)
//   valid_o          output sample valid (4 cycles after valid_i)
//   ovf_o            sticky: at least one output was saturated
// ============================================================================
module carrier_derotator #(
    parameter int LUT_BITS = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enbl_i,
    input  logic               valid_i,
    input  logic signed [15:0] dataI_i,
    input  logic signed [15:0] dataQ_i,
    input  logic [31:0]        freq_i,
    input  logic [15:0]        phase_i,
    output logic signed [15:0] dataI_o,
    output logic signed [15:0] dataQ_o,
    output logic               valid_o,
    output logic               ovf_o
);

    localparam int N  = 1 << LUT_BITS;
    localparam int NQ = N / 4;
    // Table holds NQ+1 entries, so the address needs one bit more than r.
    localparam int AW = LUT_BITS - 1;

    // round(32767 * sin(2*pi*k/N)), evaluated at elaboration time
    function automatic int sin_q15(input int k);
        real ang;
        ang = 6.283185307179586 * real'(k) / real'(N);
        return $rtoi(32767.0 * $sin(ang) + 0.5);
    endfunction

    // ------------------------------------------------------------------
    // Quarter-wave ROM (magnitudes only, all non-negative)
    // ------------------------------------------------------------------
    logic [14:0] w_lut [0:NQ];

    for (genvar gi = 0; gi <= NQ; gi++) begin : g_lut
        localparam int C_VAL = sin_q15(gi);
        assign w_lut[gi] = 15'(C_VAL);
    end

    // ------------------------------------------------------------------
    // Angle generation
    // ------------------------------------------------------------------
    logic [15:0] w_theta;

`ifdef DEROT_NCO_EN
    logic [31:0] r_acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc <= '0;
        end else if (!enbl_i) begin
            r_acc <= '0;
        end else if (valid_i) begin
            r_acc <= r_acc + freq_i;
        end
    end

    // Uses the accumulator value before this sample's update.
    assign w_theta = enbl_i ? (r_acc[31:16] + phase_i) : 16'h0000;
`else
    logic w_unused_freq;
    assign w_unused_freq = ^freq_i;
    assign w_theta = enbl_i ? phase_i : 16'h0000;
`endif

    // Sub-LSB angle bits below table resolution are truncated.
    logic w_unused_theta;
    assign w_unused_theta = ^w_theta[15-LUT_BITS:0];

    // ------------------------------------------------------------------
    // S1: angle index, data, valid
    // ------------------------------------------------------------------
    logic [LUT_BITS-1:0] r_idx1;
    logic signed [15:0]  r_i1, r_q1;
    logic                r_v1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx1 <= '0;
            r_i1   <= '0;
            r_q1   <= '0;
            r_v1   <= 1'b0;
        end else begin
            r_idx1 <= w_theta[15 -: LUT_BITS];
            r_i1   <= dataI_i;
            r_q1   <= dataQ_i;
            r_v1   <= valid_i;
        end
    end

    // ------------------------------------------------------------------
    // S2: quadrant fold and registered ROM read
    // cos(theta) = sin(theta + quarter turn), done on the table index.
    // Odd quadrants mirror the address, upper half negates.
    // ------------------------------------------------------------------
    logic [LUT_BITS-1:0] w_cidx;
    logic [AW-1:0]       w_saddr, w_caddr;

    assign w_cidx  = r_idx1 + LUT_BITS'(NQ);
    assign w_saddr = r_idx1[LUT_BITS-2] ? (AW'(NQ) - AW'(r_idx1[LUT_BITS-3:0]))
                                        : AW'(r_idx1[LUT_BITS-3:0]);
    assign w_caddr = w_cidx[LUT_BITS-2] ? (AW'(NQ) - AW'(w_cidx[LUT_BITS-3:0]))
                                        : AW'(w_cidx[LUT_BITS-3:0]);

    logic [14:0]        r_smag2, r_cmag2;
    logic               r_sneg2, r_cneg2;
    logic signed [15:0] r_i2, r_q2;
    logic               r_v2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_smag2 <= '0;
            r_cmag2 <= '0;
            r_sneg2 <= 1'b0;
            r_cneg2 <= 1'b0;
            r_i2    <= '0;
            r_q2    <= '0;
            r_v2    <= 1'b0;
        end else begin
            r_smag2 <= w_lut[w_saddr];
            r_cmag2 <= w_lut[w_caddr];
            r_sneg2 <= r_idx1[LUT_BITS-1];
            r_cneg2 <= w_cidx[LUT_BITS-1];
            r_i2    <= r_i1;
            r_q2    <= r_q1;
            r_v2    <= r_v1;
        end
    end

    // ------------------------------------------------------------------
    // S3: four products
    // ------------------------------------------------------------------
    logic signed [15:0] w_sin, w_cos;

    assign w_sin = r_sneg2 ? -$signed({1'b0, r_smag2}) : $signed({1'b0, r_smag2});
    assign w_cos = r_cneg2 ? -$signed({1'b0, r_cmag2}) : $signed({1'b0, r_cmag2});

    logic signed [31:0] r_ic3, r_qs3, r_qc3, r_is3;
    logic               r_v3;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ic3 <= '0;
            r_qs3 <= '0;
            r_qc3 <= '0;
            r_is3 <= '0;
            r_v3  <= 1'b0;
        end else begin
            r_ic3 <= 32'(r_i2) * 32'(w_cos);
            r_qs3 <= 32'(r_q2) * 32'(w_sin);
            r_qc3 <= 32'(r_q2) * 32'(w_cos);
            r_is3 <= 32'(r_i2) * 32'(w_sin);
            r_v3  <= r_v2;
        end
    end

    // ------------------------------------------------------------------
    // S4: sum, round half up, saturate, register outputs
    // ------------------------------------------------------------------
    // Returns {clipped, value}.
    function automatic logic [16:0] sat16(input logic signed [32:0] x);
        if (x > 33'sd32767) begin
            return {1'b1, 16'h7fff};
        end else if (x < -33'sd32768) begin
            return {1'b1, 16'h8000};
        end else begin
            return {1'b0, x[15:0]};
        end
    endfunction

    logic signed [32:0] w_isum, w_qsum, w_irnd, w_qrnd;
    logic [16:0]        w_isat, w_qsat;

    assign w_isum = 33'(r_ic3) + 33'(r_qs3);
    assign w_qsum = 33'(r_qc3) - 33'(r_is3);
    assign w_irnd = (w_isum + 33'sd16384) >>> 15;
    assign w_qrnd = (w_qsum + 33'sd16384) >>> 15;
    assign w_isat = sat16(w_irnd);
    assign w_qsat = sat16(w_qrnd);

    logic signed [15:0] r_io, r_qo;
    logic               r_vo, r_ovf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_io  <= '0;
            r_qo  <= '0;
            r_vo  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_vo <= r_v3;
            if (r_v3) begin
                r_io <= w_isat[15:0];
                r_qo <= w_qsat[15:0];
            end
            // Disable takes priority over a clip in the same cycle.
            if (!enbl_i) begin
                r_ovf <= 1'b0;
            end else if (r_v3 && (w_isat[16] || w_qsat[16])) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign dataI_o = r_io;
    assign dataQ_o = r_qo;
    assign valid_o = r_vo;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_carrier_derotator.sv
// ============================================================================
// tb_carrier_derotator
//
// Randomised and directed stimulus for carrier_derotator (LUT_BITS = 10),
// checked every cycle against a behavioural model that evaluates the
// rotation with real-valued sine, plain integer arithmetic and arrays of
// expected outputs indexed by output cycle.
// Honours DEROT_NCO_EN the same way the design does.
// ============================================================================
module tb_carrier_derotator;

    localparam int LB  = 10;
    localparam int N   = 1 << LB;
    localparam int MAX = 4096;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               enbl_i;
    logic               valid_i;
    logic signed [15:0] dataI_i, dataQ_i;
    logic [31:0]        freq_i;
    logic [15:0]        phase_i;
    logic signed [15:0] dataI_o, dataQ_o;
    logic               valid_o;
    logic               ovf_o;

    always #5 clk_i = ~clk_i;

    carrier_derotator #(.LUT_BITS(LB)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .enbl_i  (enbl_i),
        .valid_i (valid_i),
        .dataI_i (dataI_i),
        .dataQ_i (dataQ_i),
        .freq_i  (freq_i),
        .phase_i (phase_i),
        .dataI_o (dataI_o),
        .dataQ_o (dataQ_o),
        .valid_o (valid_o),
        .ovf_o   (ovf_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          exp_v    [MAX];
    bit          exp_clip [MAX];
    int          exp_i    [MAX];
    int          exp_q    [MAX];
    logic [31:0] acc_m;
    bit          ovf_m;
    int          last_i, last_q;
    int          cyc;

    bit obs_v[$];
    int obs_i[$];
    int obs_q[$];

    function automatic int ref_sin(input int k);
        real s;
        int  mag;
        s   = $sin(2.0 * 3.14159265358979323846 * real'(k % N) / real'(N));
        mag = $rtoi(((s < 0.0) ? -s : s) * 32767.0 + 0.5);
        return (s < 0.0) ? -mag : mag;
    endfunction

    function automatic int sat(input longint x, output bit clip);
        clip = 1'b0;
        if (x > 32767) begin
            clip = 1'b1;
            return 32767;
        end
        if (x < -32768) begin
            clip = 1'b1;
            return -32768;
        end
        return int'(x);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < MAX; i++) begin
            exp_v[i]    = 1'b0;
            exp_clip[i] = 1'b0;
            exp_i[i]    = 0;
            exp_q[i]    = 0;
        end
        acc_m  = '0;
        ovf_m  = 1'b0;
        last_i = 0;
        last_q = 0;
    endtask

    // One clock cycle: drive inputs, predict, advance, compare.
    task automatic step(input bit en, input bit v, input int di, input int dq,
                        input logic [31:0] fr, input logic [15:0] ph);
        logic [15:0] th;
        int          k, s, c;
        longint      ip, qp;
        bit          ci, cq;
        enbl_i  = en;
        valid_i = v;
        dataI_i = 16'(di);
        dataQ_i = 16'(dq);
        freq_i  = fr;
        phase_i = ph;
        if (v) begin
`ifdef DEROT_NCO_EN
            th = en ? (acc_m[31:16] + ph) : 16'h0000;
`else
            th = en ? ph : 16'h0000;
`endif
            k  = int'(th >> (16 - LB));
            s  = ref_sin(k);
            c  = ref_sin(k + N / 4);
            ip = longint'(di) * c + longint'(dq) * s;
            qp = longint'(dq) * c - longint'(di) * s;
            exp_v[cyc+4]    = 1'b1;
            exp_i[cyc+4]    = sat((ip + 16384) >>> 15, ci);
            exp_q[cyc+4]    = sat((qp + 16384) >>> 15, cq);
            exp_clip[cyc+4] = ci | cq;
        end
`ifdef DEROT_NCO_EN
        if (!en) acc_m = '0;
        else if (v) acc_m = acc_m + fr;
`endif
        @(posedge clk_i);
        #1;
        cyc++;
        if (!en) ovf_m = 1'b0;
        else if (exp_v[cyc] && exp_clip[cyc]) ovf_m = 1'b1;
        if (exp_v[cyc]) begin
            last_i = exp_i[cyc];
            last_q = exp_q[cyc];
        end
        check("valid_o", valid_o, exp_v[cyc]);
        check("dataI_o", dataI_o, last_i);
        check("dataQ_o", dataQ_o, last_q);
        check("ovf_o", ovf_o, ovf_m);
        obs_v.push_back(valid_o);
        if (valid_o) begin
            obs_i.push_back(int'(dataI_o));
            obs_q.push_back(int'(dataQ_o));
            $display("[TB] cyc %0d out I=%0d Q=%0d ovf=%0d", cyc, dataI_o, dataQ_o, ovf_o);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 32'h0, 16'h0);
    endtask

    task automatic clear_obs();
        obs_v.delete();
        obs_i.delete();
        obs_q.delete();
    endtask

    initial begin
        int first_v;
        bit [4:0] vpat;
        int nco_i[4];
        int nco_q[4];

        rst_i = 1'b1; enbl_i = 1'b1; valid_i = 1'b0;
        dataI_i = '0; dataQ_i = '0; freq_i = '0; phase_i = '0;
        cyc = 0;
        clear_model();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_I", dataI_o, 0);
        check("rst_Q", dataQ_o, 0);
        check("rst_ovf", ovf_o, 0);
        rst_i = 1'b0;

        // ---------------- randomised traffic ----------------
        for (int t = 0; t < 300; t++) begin
            bit en, v;
            int di, dq;
            en = ($urandom_range(0, 15) != 0);
            v  = ($urandom_range(0, 3) != 0);
            di = int'($urandom_range(0, 65535)) - 32768;
            dq = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 7) == 0) begin
                di = -32768;
                dq = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
            end
            step(en, v, di, dq, $urandom, 16'($urandom));
        end

        // ---------------- mid-stream reset ----------------
        for (int t = 0; t < 3; t++) step(1'b1, 1'b1, -32768, -32768, 32'h0, 16'h2000);
        #2 rst_i = 1'b1;
        #1;
        check("mrst_valid", valid_o, 0);
        check("mrst_I", dataI_o, 0);
        check("mrst_Q", dataQ_o, 0);
        check("mrst_ovf", ovf_o, 0);
        valid_i = 1'b0;
        clear_model();
        @(posedge clk_i);
        #1;
        cyc++;
        rst_i = 1'b0;

        // ---------------- post-release latency + zero angle ----------------
        clear_obs();
        step(1'b1, 1'b1, 16384, -8192, 32'h0, 16'h0);
        idle(5);
        first_v = -1;
        for (int i = obs_v.size() - 1; i >= 0; i--) if (obs_v[i]) first_v = i;
        check("rst_latency", first_v + 1, 4);
        check("zero_count", obs_i.size(), 1);
        check("zero_I", obs_i[0], 16384);
        check("zero_Q", obs_q[0], -8192);

        // ---------------- quarter turn ----------------
        clear_obs();
        step(1'b1, 1'b1, 16384, 0, 32'h0, 16'h4000);
        idle(4);
        check("qtr_count", obs_i.size(), 1);
        check("qtr_I", obs_i[0], 0);
        check("qtr_Q", obs_q[0], -16383);

        // ---------------- saturation and clear ----------------
        clear_obs();
        step(1'b1, 1'b1, -32768, -32768, 32'h0, 16'h2000);
        idle(4);
        check("sat_I", obs_i[0], -32768);
        check("sat_Q", obs_q[0], 0);
        check("sat_ovf", ovf_o, 1);
        step(1'b0, 1'b0, 0, 0, 32'h0, 16'h0);
        check("sat_ovf_clear", ovf_o, 0);
        idle(1);

        // ---------------- NCO steps with a bubble ----------------
        clear_obs();
        step(1'b1, 1'b1, 16384, 0, 32'h4000_0000, 16'h0);
        step(1'b1, 1'b1, 16384, 0, 32'h4000_0000, 16'h0);
        step(1'b1, 1'b0, 0, 0, 32'h4000_0000, 16'h0);
        step(1'b1, 1'b1, 16384, 0, 32'h4000_0000, 16'h0);
        step(1'b1, 1'b1, 16384, 0, 32'h4000_0000, 16'h0);
        idle(5);
`ifdef DEROT_NCO_EN
        nco_i = '{16384, 0, -16383, 0};
        nco_q = '{0, -16383, 0, 16384};
`else
        nco_i = '{16384, 16384, 16384, 16384};
        nco_q = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 5; i++) vpat[i] = obs_v[i+3];
        check("nco_bubble", vpat, 5'b11011);
        check("nco_count", obs_i.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("nco_I%0d", i), obs_i[i], nco_i[i]);
            check($sformatf("nco_Q%0d", i), obs_q[i], nco_q[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
